ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
// - Execute-to-memory boundary of the RISC-V core. Directly downstream of the ALU; consumes ALUResult plus decoded control.
// - Resolves branches and jumps, and issues a one-cycle PC redirect.
// - Presents a registered EX/MEM bundle to the memory stage through a 2-entry skid buffer with valid/ready on both sides.
// PARAMETERS
// - DATA_WIDTH  32  datapath, PC and immediate width
// - REG_ADDR_W   5  register index width
// PORTS
// - clk             in   1           single clock; all state updates on posedge
// - reset           in   1           synchronous, active-high
// - flush           in   1           kill every held and incoming op this cycle
// - in_valid        in   1           upstream bundle valid
// - in_ready        out  1           stage can accept a bundle this cycle
// - alu_result      in   DATA_WIDTH  ALU output; bit0 is the compare outcome for branch ops
// - rs2_data        in   DATA_WIDTH  store data
// - pc              in   DATA_WIDTH  PC of the instruction
// - imm             in   DATA_WIDTH  sign-extended immediate
// - branch          in   1           conditional branch (BEQ/BNE/BLT/BGE via ALU compare)
// - jal             in   1           JAL
// - jalr            in   1           JALR; alu_result holds rs1+imm
// - mem_read        in   1           load
// - mem_write       in   1           store
// - reg_write       in   1           writes rd
// - rd              in   REG_ADDR_W  destination register
// - funct3          in   3           access size/sign, passed through
// - out_valid       out  1           downstream bundle valid
// - out_ready       in   1           memory stage accepts
// - out_result      out  DATA_WIDTH  jal/jalr: pc+4; otherwise alu_result
// - out_store_data  out  DATA_WIDTH  registered rs2_data
// - out_rd, out_reg_write, out_mem_read, out_mem_write, out_funct3   out   registered control
// - redirect_valid  out  1           one-cycle pulse: fetch must restart at redirect_pc
// - redirect_pc     out  DATA_WIDTH  target address
// BEHAVIOUR
// - Reset: out_valid=0, redirect_valid=0, skid empty, redirect_pc=0, all data and control outputs 0.
// - Accept: acc = in_valid & in_ready & ~flush.
// - in_ready = ~skid_valid. It is a registered state, never combinational on out_ready.
// - Main register: loads on acc when empty or when out_ready drains it this cycle. Latency is 1 cycle: in -> out_valid next edge.
// - Skid register: on acc while main is valid and out_ready=0, the bundle is captured in skid.
// - When main drains, skid moves to main; skid moves first, so ordering is strictly FIFO.
// - At most 2 bundles are held. Full => in_ready=0. Empty => out_valid=0.
// - Bundle fields are stable while out_valid=1 and out_ready=0.
// - Taken condition: taken = jal | jalr | (branch & alu_result[0]), evaluated on acc only.
// - Target:
//   - branch/jal: pc+imm, modulo 2^DATA_WIDTH
//   - jalr: alu_result & ~1
// - Redirect:
//   - redirect_valid is registered: it is 1 exactly in the cycle after an accepted taken op, then 0.
//   - redirect_pc holds its last value otherwise.
// - pc+4 wraps modulo 2^DATA_WIDTH.
// - A branch with reg_write=0 still flows downstream; the memory stage ignores it.
// - Flush:
//   - Next edge: main and skid cleared, incoming op dropped, redirect_valid=0. Flush wins over acc and drain.
//   - in_ready is 1 the cycle after a flush.
// - reset has priority over flush. Reset mid-operation discards all held bundles with no redirect.
// - Misaligned targets are not checked here.
// STRUCTURE
// - Shared package core_pkg:
//   - typedef ex_mem_bundle_t (result, store_data, rd, reg_write, mem_read, mem_write, funct3)
//   - constant PC_STEP = 4
// - One sub-module, skid_buffer #(type T), holds the 2-entry valid/ready buffer.
// - Branch resolution and redirect logic stay in ex_mem_stage.
// TESTING
// - Reset held 2 cycles with in_valid=1 -> out_valid=0, redirect_valid=0, in_ready=1 after release.
// - Stream 3 ops, out_ready=1, alu_result=0x10,0x20,0x30 -> out_result 0x10,0x20,0x30 on consecutive cycles, 1-cycle latency.
// - out_ready=0 while 2 ops arrive -> in_ready=0 after the 2nd; release -> both delivered in order, none lost or duplicated.
// - Taken branch: branch=1, alu_result=1, pc=0x100, imm=-8 -> next cycle redirect_valid=1, redirect_pc=0xF8.
//   - Same op with alu_result=0 -> no redirect.
// - jalr with alu_result=0x2003, pc=0x40 -> redirect_pc=0x2002, out_result=0x44.
//   - jal with pc=0xFFFFFFFC -> out_result=0x0 (wrap).
// - flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, redirect_valid=0.

Source files
------------

// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared types and constants for the RISC-V core pipeline.
//   XLEN            datapath / PC / immediate width
//   REG_AW          register index width
//   PC_STEP         sequential PC increment (link address = pc + PC_STEP)
//   ex_mem_bundle_t payload carried across the EX/MEM boundary
//   jalr_target()   clears bit 0 of the JALR sum
// -----------------------------------------------------------------------------
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef struct packed {
        logic [XLEN-1:0]   result;
        logic [XLEN-1:0]   store_data;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic [2:0]        funct3;
    } ex_mem_bundle_t;

    // JALR jumps to (rs1 + imm) with the least significant bit forced to zero.
    function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] sum);
        return {sum[XLEN-1:1], 1'b0};
    endfunction

endpackage : core_pkg

// File: rtl/ex_mem_stage_if.sv
// -----------------------------------------------------------------------------
// ex_mem_stage_if
// Bundles every data/handshake signal of the EX/MEM stage.
//   Upstream side  : in_valid/in_ready, alu_result, rs2_data, pc, imm,
//                    branch, jal, jalr, mem_read, mem_write, reg_write, rd, funct3
//   Downstream side: out_valid/out_ready, out_result, out_store_data, out_rd,
//                    out_reg_write, out_mem_read, out_mem_write, out_funct3
//   Fetch side     : redirect_valid, redirect_pc
// Modports
//   slave  : the stage itself
//   master : the surrounding pipeline (execute, memory and fetch stages)
// -----------------------------------------------------------------------------
interface ex_mem_stage_if #(
    parameter int DATA_WIDTH = core_pkg::XLEN,
    parameter int REG_ADDR_W = core_pkg::REG_AW
);

    // upstream bundle
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] alu_result;
    logic [DATA_WIDTH-1:0] rs2_data;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] imm;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd;
    logic [2:0]            funct3;

    // downstream bundle
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_result;
    logic [DATA_WIDTH-1:0] out_store_data;
    logic [REG_ADDR_W-1:0] out_rd;
    logic                  out_reg_write;
    logic                  out_mem_read;
    logic                  out_mem_write;
    logic [2:0]            out_funct3;

    // fetch redirect
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;

    modport slave (
        input  in_valid, alu_result, rs2_data, pc, imm,
               branch, jal, jalr, mem_read, mem_write, reg_write, rd, funct3,
               out_ready,
        output in_ready,
               out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_funct3,
               redirect_valid, redirect_pc
    );

    modport master (
        output in_valid, alu_result, rs2_data, pc, imm,
               branch, jal, jalr, mem_read, mem_write, reg_write, rd, funct3,
               out_ready,
        input  in_ready,
               out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_funct3,
               redirect_valid, redirect_pc
    );

endinterface : ex_mem_stage_if

// File: rtl/ex_mem_stage_skid.sv
// -----------------------------------------------------------------------------
// skid_buffer
// Two-entry valid/ready buffer (main + skid register), strictly FIFO.
//   clk, reset  clock, synchronous active-high reset
//   flush       empties both entries; wins over push and drain
//   push        qualified write (caller has already checked in_ready)
//   in_data     payload to store on push
//   in_ready    registered: 1 whenever the skid entry is free
//   out_valid   main entry holds a payload
//   out_ready   consumer takes main this cycle
//   out_data    main entry payload, stable while out_valid & ~out_ready
// -----------------------------------------------------------------------------
module skid_buffer #(
    parameter type T = logic
) (
    input  logic clk,
    input  logic reset,
    input  logic flush,
    input  logic push,
    input  T     in_data,
    output logic in_ready,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    logic main_valid;
    logic skid_valid;
    T     main_q;
    T     skid_q;
    logic drain;

    assign drain     = main_valid & out_ready;
    assign in_ready  = ~skid_valid;
    assign out_valid = main_valid;
    assign out_data  = main_q;

    // A push while the skid entry is occupied cannot happen because in_ready
    // is low then; the skid-occupied branch therefore only handles the drain.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: payload registers are reset as well as the valid bits so
            // the outputs read as zero after reset, not as stale data.
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (skid_valid) begin
            if (drain) begin
                // skid moves up first; main stays valid with the older entry
                main_q     <= skid_q;
                skid_valid <= 1'b0;
            end
        end else if (push) begin
            if (main_valid && !out_ready) begin
                // main is held: park the new payload in the skid entry
                skid_q     <= in_data;
                skid_valid <= 1'b1;
            end else begin
                // NOTE: non-blocking assignments let main_q be refilled in the
                // same edge it is consumed without ordering hazards.
                main_q     <= in_data;
                main_valid <= 1'b1;
            end
        end else if (drain) begin
            main_valid <= 1'b0;
        end
    end

endmodule : skid_buffer

// File: rtl/ex_mem_stage.sv
// -----------------------------------------------------------------------------
// ex_mem_stage
// Execute-to-memory boundary: resolves branches/jumps, raises a one-cycle
// registered PC redirect, and hands a registered EX/MEM bundle to the memory
// stage through a 2-entry skid buffer.
//   clk    single clock, all state on posedge
//   reset  synchronous, active-high; beats flush
//   flush  kills held and incoming ops on the next edge
//   bus    ex_mem_stage_if.slave: upstream bundle, downstream bundle, redirect
// Instantiate the interface with the same DATA_WIDTH / REG_ADDR_W as this
// module; the bundle type is sized by core_pkg (XLEN / REG_AW).
// -----------------------------------------------------------------------------
module ex_mem_stage
    import core_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int REG_ADDR_W = REG_AW
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    ex_mem_stage_if.slave  bus
);

    logic                  acc;
    logic                  taken;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] link_addr;
    logic [DATA_WIDTH-1:0] target;
    logic [REG_ADDR_W-1:0] rd_in;
    ex_mem_bundle_t        in_bundle;
    ex_mem_bundle_t        out_bundle;
    logic                  out_valid;
    logic                  redirect_valid_q;
    logic [DATA_WIDTH-1:0] redirect_pc_q;

    assign acc       = bus.in_valid & in_ready & ~flush;
    assign taken     = bus.jal | bus.jalr | (bus.branch & bus.alu_result[0]);
    assign link_addr = bus.pc + PC_STEP;   // wraps modulo 2^DATA_WIDTH
    assign rd_in     = bus.rd;

    // Target selection and bundle formation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        target    = bus.pc + bus.imm;
        in_bundle = '0;

        if (bus.jalr) begin
            target = jalr_target(bus.alu_result);
        end

        in_bundle.result     = (bus.jal | bus.jalr) ? link_addr : bus.alu_result;
        in_bundle.store_data = bus.rs2_data;
        in_bundle.rd         = rd_in;
        in_bundle.reg_write  = bus.reg_write;
        in_bundle.mem_read   = bus.mem_read;
        in_bundle.mem_write  = bus.mem_write;
        in_bundle.funct3     = bus.funct3;
    end

    skid_buffer #(
        .T (ex_mem_bundle_t)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (acc),
        .in_data   (in_bundle),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_bundle)
    );

    // Redirect: a single-cycle pulse after each accepted taken op. The target
    // register keeps its last value between pulses and across a flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (flush) begin
            redirect_valid_q <= 1'b0;
        end else begin
            redirect_valid_q <= acc & taken;
            if (acc && taken) begin
                redirect_pc_q <= target;
            end
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid;
    assign bus.out_result     = out_bundle.result;
    assign bus.out_store_data = out_bundle.store_data;
    assign bus.out_rd         = out_bundle.rd;
    assign bus.out_reg_write  = out_bundle.reg_write;
    assign bus.out_mem_read   = out_bundle.mem_read;
    assign bus.out_mem_write  = out_bundle.mem_write;
    assign bus.out_funct3     = out_bundle.funct3;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule : ex_mem_stage

// File: tb/tb_ex_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_ex_mem_stage
// Directed bench for ex_mem_stage. Every accepted op pushes its expected
// bundle onto a queue; every downstream handshake pops and compares it.
// Directed checks cover reset, latency, back-pressure, redirects, wrap,
// flush and mid-operation reset.
// -----------------------------------------------------------------------------
module tb_ex_mem_stage;
    import core_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic flush;

    always #5 clk = ~clk;

    ex_mem_stage_if #(.DATA_WIDTH(XLEN), .REG_ADDR_W(REG_AW)) bus ();

    ex_mem_stage #(.DATA_WIDTH(XLEN), .REG_ADDR_W(REG_AW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    ex_mem_bundle_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Expected bundle for the op currently on the upstream inputs.
    function automatic ex_mem_bundle_t expected_bundle();
        ex_mem_bundle_t e;
        e.result     = (bus.jal || bus.jalr) ? bus.pc + 32'd4 : bus.alu_result;
        e.store_data = bus.rs2_data;
        e.rd         = bus.rd;
        e.reg_write  = bus.reg_write;
        e.mem_read   = bus.mem_read;
        e.mem_write  = bus.mem_write;
        e.funct3     = bus.funct3;
        return e;
    endfunction

    // Evaluated mid-cycle, before the edge that commits the handshakes.
    task automatic sb_sample();
        ex_mem_bundle_t e;
        if (reset || flush) begin
            sb_q.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                check("sb_has_entry", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("sb_result", bus.out_result, e.result);
                    check("sb_store_data", bus.out_store_data, e.store_data);
                    check("sb_ctrl",
                          32'({bus.out_rd, bus.out_reg_write, bus.out_mem_read,
                               bus.out_mem_write, bus.out_funct3}),
                          32'({e.rd, e.reg_write, e.mem_read, e.mem_write, e.funct3}));
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(expected_bundle());
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_sample();
        @(posedge clk);
        #1;
    endtask

    // ctl = {branch, jal, jalr}; mem = {mem_read, mem_write, reg_write}
    task automatic drive(input logic [31:0] alu, input logic [31:0] rs2,
                         input logic [31:0] pc_v, input logic [31:0] imm_v,
                         input logic [2:0] ctl, input logic [2:0] mem,
                         input logic [4:0] rd_v, input logic [2:0] f3);
        bus.in_valid   = 1'b1;
        bus.alu_result = alu;
        bus.rs2_data   = rs2;
        bus.pc         = pc_v;
        bus.imm        = imm_v;
        {bus.branch, bus.jal, bus.jalr}             = ctl;
        {bus.mem_read, bus.mem_write, bus.reg_write} = mem;
        bus.rd         = rd_v;
        bus.funct3     = f3;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
        {bus.branch, bus.jal, bus.jalr} = 3'b000;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b1;
        flush         = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'hDEAD, 32'h1, 32'h1000, 32'h4, 3'b010, 3'b001, 5'd3, 3'd0);

        // Reset held two cycles with in_valid=1
        tick();
        tick();
        reset = 1'b0;
        idle();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_redirect_pc", bus.redirect_pc, 32'h0);
        check("rst_out_result", bus.out_result, 32'h0);

        // Stream three ops with out_ready=1: one-cycle latency, back-to-back
        drive(32'h10, 32'hA1, 32'h0, 32'h0, 3'b000, 3'b001, 5'd1, 3'd2);
        tick();
        check("stream_valid0", 32'(bus.out_valid), 32'd1);
        check("stream_res0", bus.out_result, 32'h10);
        drive(32'h20, 32'hA2, 32'h4, 32'h0, 3'b000, 3'b100, 5'd2, 3'd4);
        tick();
        check("stream_res1", bus.out_result, 32'h20);
        drive(32'h30, 32'hA3, 32'h8, 32'h0, 3'b000, 3'b010, 5'd0, 3'd1);
        tick();
        check("stream_res2", bus.out_result, 32'h30);
        idle();
        tick();
        check("stream_empty", 32'(bus.out_valid), 32'd0);

        // Back-pressure: two ops fill main + skid, a third is refused
        bus.out_ready = 1'b0;
        drive(32'h40, 32'hB0, 32'h10, 32'h0, 3'b000, 3'b001, 5'd4, 3'd0);
        tick();
        check("bp_ready_after1", 32'(bus.in_ready), 32'd1);
        drive(32'h50, 32'hB1, 32'h14, 32'h0, 3'b000, 3'b001, 5'd5, 3'd0);
        tick();
        check("bp_ready_after2", 32'(bus.in_ready), 32'd0);
        check("bp_hold_a", bus.out_result, 32'h40);
        drive(32'h60, 32'hB2, 32'h18, 32'h0, 3'b000, 3'b001, 5'd6, 3'd0);
        tick();
        check("bp_still_full", 32'(bus.in_ready), 32'd0);
        check("bp_stable_a", bus.out_result, 32'h40);
        idle();
        bus.out_ready = 1'b1;
        tick();
        check("bp_second", bus.out_result, 32'h50);
        check("bp_ready_again", 32'(bus.in_ready), 32'd1);
        tick();
        check("bp_drained", 32'(bus.out_valid), 32'd0);
        check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        // Taken branch: pc=0x100, imm=-8
        drive(32'h1, 32'h0, 32'h100, 32'hFFFF_FFF8, 3'b100, 3'b000, 5'd0, 3'd0);
        tick();
        check("br_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("br_redirect_pc", bus.redirect_pc, 32'h0000_00F8);
        check("br_flows_down", 32'(bus.out_valid), 32'd1);
        idle();
        tick();
        check("br_pulse_ends", 32'(bus.redirect_valid), 32'd0);
        check("br_pc_holds", bus.redirect_pc, 32'h0000_00F8);
        // Same branch, compare false: no redirect
        drive(32'h0, 32'h0, 32'h100, 32'hFFFF_FFF8, 3'b100, 3'b000, 5'd0, 3'd0);
        tick();
        check("nt_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("nt_pc_holds", bus.redirect_pc, 32'h0000_00F8);

        // JALR clears bit 0; link = pc+4
        drive(32'h2003, 32'h0, 32'h40, 32'h5, 3'b001, 3'b001, 5'd1, 3'd0);
        tick();
        check("jalr_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        check("jalr_redirect_pc", bus.redirect_pc, 32'h2002);
        check("jalr_link", bus.out_result, 32'h44);
        // JAL at the top of the address space: link and target wrap
        drive(32'h5555, 32'h0, 32'hFFFF_FFFC, 32'h10, 3'b010, 3'b001, 5'd1, 3'd0);
        tick();
        check("jal_link_wrap", bus.out_result, 32'h0);
        check("jal_target_wrap", bus.redirect_pc, 32'h0000_000C);
        check("jal_redirect_valid", 32'(bus.redirect_valid), 32'd1);
        idle();
        tick();

        // Flush with both entries full and a taken op waiting upstream
        bus.out_ready = 1'b0;
        drive(32'h80, 32'hCAFE, 32'h1F0, 32'h0, 3'b000, 3'b010, 5'd0, 3'd2);
        tick();
        drive(32'h0, 32'h0, 32'h200, 32'h40, 3'b010, 3'b001, 5'd7, 3'd0);
        tick();
        check("fl_full", 32'(bus.in_ready), 32'd0);
        check("fl_pre_redirect", bus.redirect_pc, 32'h240);
        flush = 1'b1;
        drive(32'h0, 32'h0, 32'h300, 32'h8, 3'b010, 3'b001, 5'd8, 3'd0);
        tick();
        flush = 1'b0;
        idle();
        check("fl_out_valid", 32'(bus.out_valid), 32'd0);
        check("fl_in_ready", 32'(bus.in_ready), 32'd1);
        check("fl_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("fl_redirect_pc_holds", bus.redirect_pc, 32'h240);
        bus.out_ready = 1'b1;
        tick();
        check("fl_nothing_left", 32'(bus.out_valid), 32'd0);
        // Flush beats an acceptable incoming jump
        flush = 1'b1;
        drive(32'h0, 32'h0, 32'h400, 32'h8, 3'b010, 3'b001, 5'd9, 3'd0);
        tick();
        flush = 1'b0;
        idle();
        check("fl_drop_valid", 32'(bus.out_valid), 32'd0);
        check("fl_drop_redirect", 32'(bus.redirect_valid), 32'd0);

        // Reset mid-operation with a redirect pending
        bus.out_ready = 1'b0;
        drive(32'h90, 32'h1, 32'h500, 32'h0, 3'b000, 3'b001, 5'd2, 3'd0);
        tick();
        drive(32'h0, 32'h0, 32'h504, 32'h4, 3'b010, 3'b001, 5'd3, 3'd0);
        tick();
        check("mr_redirect_before", 32'(bus.redirect_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        check("mr_out_valid", 32'(bus.out_valid), 32'd0);
        check("mr_redirect_valid", 32'(bus.redirect_valid), 32'd0);
        check("mr_redirect_pc", bus.redirect_pc, 32'h0);
        check("mr_in_ready", 32'(bus.in_ready), 32'd1);
        check("mr_out_result", bus.out_result, 32'h0);

        // Normal traffic resumes after reset
        bus.out_ready = 1'b1;
        drive(32'h77, 32'h7, 32'h600, 32'h0, 3'b000, 3'b001, 5'd11, 3'd5);
        tick();
        check("post_reset_res", bus.out_result, 32'h77);
        idle();
        tick();
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_ex_mem_stage
